pipeline_dmem_ctrl: RTL and testbench

//   Multi-cycle data-memory controller directly downstream of the pipeline Mem stage.

---
 rtl/pipeline_dmem_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_dmem_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_dmem_ctrl.sv
// Multi-cycle data-memory controller behind the pipeline Mem stage.
// Stalls the whole pipeline for LATENCY+1 cycles per access and then pulses done_o for one cycle.
module pipeline_dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        MemRW_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] Data_w_i,
    output logic [31:0] Data_r_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0]      mem [DEPTH_WORDS];
    logic             mem_we;
    logic             aligned;
    logic             in_range;
    logic [IDX_W-1:0] ram_idx;

    assign aligned  = (Addr_i[1:0] == 2'b00);
    // Range is judged on the full 30-bit word index so high addresses never alias into the RAM.
    assign in_range = ({2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS));
    assign ram_idx  = addr_q[IDX_W+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        stall_o = 1'b0;
        done_o  = 1'b0;
        err_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    if (aligned) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                        addr_d  = Addr_i;
                        wdata_d = Data_w_i;
                        rw_d    = MemRW_i;
                        stall_o = 1'b1;
                    end else begin
                        err_o = 1'b1;
                        if (!MemRW_i) begin
                            rdata_d = 32'h0;
                        end
                    end
                end
            end
            S_WAIT: begin
                stall_o = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    if (rw_q) begin
                        mem_we = in_range;
                    end else begin
                        rdata_d = in_range ? mem[ram_idx] : 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                // The finishing instruction is still in Mem this cycle, so req_i is ignored.
                done_o  = 1'b1;
                err_o   = ~in_range;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rw_q    <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM is never cleared; reset forces IDLE immediately, which kills any pending write enable.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ram_idx] <= wdata_q;
        end
    end

    assign Data_r_o = rdata_q;

endmodule

// File: tb/tb_pipeline_dmem_ctrl.sv
// Self-checking bench for pipeline_dmem_ctrl: directed vector table, reset/hold sequences,
// and randomized accesses compared against a word-array reference model.
module tb_pipeline_dmem_ctrl;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0;
    logic        MemRW_i = 1'b0;
    logic [31:0] Addr_i = 32'h0;
    logic [31:0] Data_w_i = 32'h0;
    logic [31:0] Data_r_o;
    logic        stall_o, done_o, err_o;

    int n_chk  = 0;
    int n_fail = 0;

    pipeline_dmem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .MemRW_i  (MemRW_i),
        .Addr_i   (Addr_i),
        .Data_w_i (Data_w_i),
        .Data_r_o (Data_r_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        got;
        int          stall;
        logic        done;
        logic        err;
        logic [31:0] rd;
    } res_t;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
        logic        done;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Called at posedge+1; holds the request until the access finishes, returns at posedge+1.
    task automatic access(input logic rw, input logic [31:0] a, input logic [31:0] d,
                          output res_t r);
        r.got = 1'b0; r.stall = 0; r.done = 1'b0; r.err = 1'b0; r.rd = 32'h0;
        req_i = 1'b1; MemRW_i = rw; Addr_i = a; Data_w_i = d;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall_o) r.stall++;
            if (done_o || !stall_o) begin
                r.got  = 1'b1;
                r.done = done_o;
                r.err  = err_o;
                r.rd   = Data_r_o;
                @(posedge clk); #1;
                if (!r.done) r.rd = Data_r_o;
                break;
            end
        end
        req_i = 1'b0;
    endtask

    task automatic check_res(input string nm, input res_t r, input int st, input logic dn,
                             input logic er, input logic [31:0] rd);
        chk({nm, " finished"}, 32'(r.got), 32'd1);
        chk({nm, " stall_cycles"}, 32'(r.stall), 32'(st));
        chk({nm, " done"}, 32'(r.done), 32'(dn));
        chk({nm, " err"}, 32'(r.err), 32'(er));
        chk({nm, " Data_r_o"}, r.rd, rd);
    endtask

    task automatic idle_check(input string nm, input logic [31:0] rd);
        @(negedge clk);
        chk({nm, " stall"}, 32'(stall_o), 32'd0);
        chk({nm, " done"}, 32'(done_o), 32'd0);
        chk({nm, " err"}, 32'(err_o), 32'd0);
        chk({nm, " Data_r_o"}, Data_r_o, rd);
        @(posedge clk); #1;
    endtask

    function automatic vec_t mkv(logic rw, logic [31:0] a, logic [31:0] d, int st,
                                 logic dn, logic er, logic [31:0] rd);
        vec_t v;
        v.rw = rw; v.addr = a; v.wdata = d; v.stall = st; v.done = dn; v.err = er; v.rd = rd;
        return v;
    endfunction

    vec_t        vt [12];
    logic [31:0] model [16];
    res_t        r;
    logic [31:0] exp_rd;

    initial begin
        vt[0]  = mkv(1'b1, 32'h20,       32'hDEADBEEF, LAT+1, 1'b1, 1'b0, 32'h11111111);
        vt[1]  = mkv(1'b0, 32'h20,       32'h0,        LAT+1, 1'b1, 1'b0, 32'hDEADBEEF);
        vt[2]  = mkv(1'b1, 32'h4,        32'h5,        LAT+1, 1'b1, 1'b0, 32'hDEADBEEF);
        vt[3]  = mkv(1'b0, 32'h4,        32'h0,        LAT+1, 1'b1, 1'b0, 32'h5);
        vt[4]  = mkv(1'b0, 32'h22,       32'h0,        0,     1'b0, 1'b1, 32'h0);
        vt[5]  = mkv(1'b1, 32'h0,        32'hA5A5A5A5, LAT+1, 1'b1, 1'b0, 32'h0);
        vt[6]  = mkv(1'b0, 32'h0,        32'h0,        LAT+1, 1'b1, 1'b0, 32'hA5A5A5A5);
        vt[7]  = mkv(1'b1, 32'h3,        32'h77777777, 0,     1'b0, 1'b1, 32'hA5A5A5A5);
        vt[8]  = mkv(1'b0, 32'(4*DEPTH), 32'h0,        LAT+1, 1'b1, 1'b1, 32'h0);
        vt[9]  = mkv(1'b1, 32'(4*DEPTH), 32'h12345678, LAT+1, 1'b1, 1'b1, 32'h0);
        vt[10] = mkv(1'b0, 32'hFFFFFFFC, 32'h0,        LAT+1, 1'b1, 1'b1, 32'h0);
        vt[11] = mkv(1'b0, 32'h0,        32'h0,        LAT+1, 1'b1, 1'b0, 32'hA5A5A5A5);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", 32'(stall_o), 32'd0);
        chk("reset done", 32'(done_o), 32'd0);
        chk("reset err", 32'(err_o), 32'd0);
        chk("reset Data_r_o", Data_r_o, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset abandoning a store in its last WAIT cycle
        access(1'b1, 32'h10, 32'h11111111, r);
        check_res("pre store 0x10", r, LAT+1, 1'b1, 1'b0, 32'h0);
        access(1'b0, 32'h10, 32'h0, r);
        check_res("pre load 0x10", r, LAT+1, 1'b1, 1'b0, 32'h11111111);
        req_i = 1'b1; MemRW_i = 1'b1; Addr_i = 32'h10; Data_w_i = 32'h22222222;
        repeat (LAT) @(posedge clk);
        #1;
        chk("mid-wait stall", 32'(stall_o), 32'd1);
        req_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("async reset stall", 32'(stall_o), 32'd0);
        chk("async reset Data_r_o", Data_r_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_check("post reset idle", 32'h0);
        idle_check("post reset idle2", 32'h0);
        access(1'b0, 32'h10, 32'h0, r);
        check_res("load 0x10 after reset", r, LAT+1, 1'b1, 1'b0, 32'h11111111);

        // Directed vectors, issued back-to-back
        for (int i = 0; i < 12; i++) begin
            access(vt[i].rw, vt[i].addr, vt[i].wdata, r);
            check_res($sformatf("vec%0d", i), r, vt[i].stall, vt[i].done, vt[i].err, vt[i].rd);
        end

        // Load result held while idle; done_o is a single-cycle pulse
        for (int i = 0; i < 4; i++) idle_check($sformatf("hold%0d", i), 32'hA5A5A5A5);

        // Randomized accesses against a word-array model of 16 words at 0x100
        for (int k = 0; k < 16; k++) begin
            model[k] = $urandom;
            access(1'b1, 32'h100 + 32'(4*k), model[k], r);
            check_res($sformatf("init%0d", k), r, LAT+1, 1'b1, 1'b0, 32'hA5A5A5A5);
        end
        exp_rd = 32'hA5A5A5A5;
        for (int n = 0; n < 150; n++) begin
            int          pick, k;
            logic        rw, mis, oor;
            logic [31:0] a, d;
            pick = int'($urandom_range(0, 9));
            k    = int'($urandom_range(0, 15));
            rw   = 1'($urandom_range(0, 1));
            d    = $urandom;
            a    = 32'h100 + 32'(4*k);
            if (pick == 0) a = a + 32'($urandom_range(1, 3));
            if (pick == 1) a = 32'h1100 + 32'(4*k);
            mis = (a % 4) != 0;
            oor = (a / 4) >= DEPTH;
            if (!rw) begin
                if (mis || oor) exp_rd = 32'h0;
                else exp_rd = model[k];
            end else if (!mis && !oor) begin
                model[k] = d;
            end
            access(rw, a, d, r);
            check_res($sformatf("rnd%0d", n), r, mis ? 0 : LAT+1, !mis, mis || oor, exp_rd);
            if ($urandom_range(0, 3) == 0) idle_check($sformatf("rnd_gap%0d", n), exp_rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
